// File: rtl/sha256_pkg.sv
// Shared SHA-256 controller definitions: phase codes and block/digest geometry.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_LOAD     = 3'b001,
    ST_PRIME    = 3'b010,
    ST_COMPRESS = 3'b011,
    ST_OUTPUT   = 3'b100
  } core_state_e;

  localparam int SHA_N_ROUNDS     = 64;
  localparam int SHA_WORD_COUNT   = 16;
  localparam int SHA_DIGEST_COUNT = 8;
  localparam int CNT_W            = 7;

  function automatic logic [CNT_W-1:0] last_index(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/sha256_round_counter.sv
// Word/round/digest index counter; it self-clears on terminal count so it never wraps.
module sha256_round_counter
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || (en && tc)) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sha256_core_ctrl.sv
// SHA-256 block sequencer: load 16 words, prime, N_ROUNDS compress cycles, stream 8 digest words.
module sha256_core_ctrl
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_ROUNDS   = SHA_N_ROUNDS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       win_valid,
  output logic       win_ready,
  output logic [2:0] core_state,
  output logic [6:0] core_count,
  output logic       core_init,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy,
  output logic       done
);

  if (DATA_WIDTH != 32 || N_ROUNDS < 1 || N_ROUNDS > (1 << CNT_W)) begin : g_param_check
    $error("sha256_core_ctrl: unsupported DATA_WIDTH or N_ROUNDS");
  end

  core_state_e      state;
  logic             adv;
  logic             cnt_clr;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_last;

  // adv is the per-phase "index moves on" condition; cnt_last is that phase's final index
  always_comb begin
    adv      = 1'b0;
    cnt_last = '0;
    unique case (state)
      ST_LOAD: begin
        adv      = win_valid;
        cnt_last = last_index(SHA_WORD_COUNT);
      end
      ST_COMPRESS: begin
        adv      = 1'b1;
        cnt_last = last_index(N_ROUNDS);
      end
      ST_OUTPUT: begin
        adv      = dout_ready;
        cnt_last = last_index(SHA_DIGEST_COUNT);
      end
      default: ;
    endcase
  end

  assign cnt_clr = abort || (state == ST_IDLE) || (state == ST_PRIME);

  sha256_round_counter u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (adv),
    .last  (cnt_last),
    .count (core_count),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:     if (start) state <= ST_LOAD;
        ST_LOAD:     if (adv && cnt_tc) state <= ST_PRIME;
        ST_PRIME:    state <= ST_COMPRESS;
        ST_COMPRESS: if (cnt_tc) state <= ST_OUTPUT;
        ST_OUTPUT:   if (adv && cnt_tc) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Strobes fire in the cycle of the event itself, so done never overlaps an IDLE cycle
  assign core_state = state;
  assign win_ready  = (state == ST_LOAD);
  assign dout_valid = (state == ST_OUTPUT);
  assign busy       = (state != ST_IDLE);
  assign core_init  = (state == ST_IDLE) && start && !abort;
  assign done       = (state == ST_OUTPUT) && dout_ready && cnt_tc && !abort;

endmodule

// File: tb/tb_sha256_core_ctrl.sv
// Bench for sha256_core_ctrl: a behavioural SHA-256 datapath follows the controller's phase/index outputs.
module tb_sha256_core_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       win_valid = 1'b0;
  logic       win_ready;
  logic [2:0] core_state;
  logic [6:0] core_count;
  logic       core_init;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       busy;
  logic       done;

  logic [31:0] win_data = '0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  sha256_core_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .win_valid(win_valid), .win_ready(win_ready),
    .core_state(core_state), .core_count(core_count), .core_init(core_init),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  localparam logic [31:0] H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] ABC_DIGEST [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0][31:0] sha_round(input logic [7:0][31:0] v, input logic [31:0] k,
                                                input logic [31:0] w);
    logic [31:0] t1, t2;
    logic [7:0][31:0] r;
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w;
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    r[7] = v[6]; r[6] = v[5]; r[5] = v[4]; r[4] = v[3] + t1;
    r[3] = v[2]; r[2] = v[1]; r[1] = v[0]; r[0] = t1 + t2;
    return r;
  endfunction

  // Datapath model: sliding 16-word schedule window, working vars a..h in wv[0..7]
  logic [15:0][31:0] win_q;
  logic [7:0][31:0]  wv;
  logic [31:0]       sched_next;
  logic [31:0]       dout_data;

  assign sched_next = (rotr(win_q[14], 17) ^ rotr(win_q[14], 19) ^ (win_q[14] >> 10)) + win_q[9]
                    + (rotr(win_q[1], 7) ^ rotr(win_q[1], 18) ^ (win_q[1] >> 3)) + win_q[0];
  assign dout_data  = H_INIT[core_count[2:0]] + wv[core_count[2:0]];

  always @(posedge clk) begin
    if (core_init)
      for (int i = 0; i < 8; i++) wv[i] <= H_INIT[i];
    if (win_valid && win_ready)
      win_q[core_count[3:0]] <= win_data;
    if (core_state == 3'b011) begin
      wv    <= sha_round(wv, K[core_count[5:0]], win_q[0]);
      win_q <= {sched_next, win_q[15:1]};
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dout_valid && dout_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_word got %h, expected no output", dout_data);
      end else begin
        logic [31:0] exp_w;
        exp_w = sb.pop_front();
        if (dout_data !== exp_w) begin
          errors++;
          $display("FAIL digest_word idx %0d got %h expected %h", core_count, dout_data, exp_w);
        end
      end
    end
  end

  function automatic logic [31:0] abc_word(input int i);
    if (i == 0) return 32'h61626380;
    if (i == 15) return 32'h00000018;
    return 32'h0;
  endfunction

  task automatic push_abc();
    for (int i = 0; i < 8; i++) sb.push_back(ABC_DIGEST[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_words(input int nwords, input bit toggle);
    int n = 0;
    int guard = 0;
    bit phase = 1'b1;
    bit acc;
    while (n < nwords && guard < 200) begin
      win_data  = abc_word(n);
      win_valid = toggle ? phase : 1'b1;
      @(negedge clk);
      acc = win_valid && win_ready;
      @(posedge clk); #1;
      if (acc) n++;
      phase = ~phase;
      guard++;
    end
    win_valid = 1'b0;
    if (n < nwords) begin
      checks++; errors++;
      $display("FAIL load_timeout accepted %0d required %0d", n, nwords);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy %b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({core_state, core_count, win_ready, core_init, dout_valid, busy, done} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state got st=%0d cnt=%0d wr=%b ci=%b dv=%b busy=%b done=%b required all 0",
               core_state, core_count, win_ready, core_init, dout_valid, busy, done);
    end
  endtask

  task automatic test_abc();
    int d0, lat;
    d0 = done_cnt;
    dout_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (core_init !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL core_init_pulse got init=%b busy=%b required init=1 busy=0", core_init, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (core_state !== 3'b001 || core_count !== 7'd0 || win_ready !== 1'b1) begin
      errors++;
      $display("FAIL enter_load got st=%0d cnt=%0d wr=%b required 1/0/1", core_state, core_count, win_ready);
    end
    push_abc();
    load_words(16, 1'b0);
    lat = 0;
    while (!dout_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 65) begin
      errors++;
      $display("FAIL latency got %0d cycles required 65", lat);
    end
    wait_idle();
    checks++;
    if (done_cnt - d0 != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL abc_done got done=%0d left=%0d required done=1 left=0", done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_toggle();
    int n = 0;
    int guard = 0;
    bit acc;
    dout_ready = 1'b1;
    pulse_start();
    push_abc();
    while (n < 16 && guard < 100) begin
      win_data  = abc_word(n);
      win_valid = guard[0] ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if (core_count !== 7'(n) || core_state !== 3'b001) begin
        errors++;
        $display("FAIL toggle_count got st=%0d cnt=%0d required st=1 cnt=%0d", core_state, core_count, n);
      end
      acc = win_valid && win_ready;
      @(posedge clk); #1;
      if (acc) n++;
      guard++;
    end
    win_valid = 1'b0;
    checks++;
    if (core_state !== 3'b010 || core_count !== 7'd0 || guard != 31) begin
      errors++;
      $display("FAIL toggle_prime got st=%0d cnt=%0d cycles=%0d required st=2 cnt=0 cycles=31",
               core_state, core_count, guard);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int guard = 0;
    dout_ready = 1'b1;
    pulse_start();
    push_abc();
    load_words(16, 1'b0);
    while (!(dout_valid && core_count == 7'd3) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (core_count !== 7'd3 || dout_valid !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got cnt=%0d dv=%b done=%b required 3/1/0",
                 i, core_count, dout_valid, done);
      end
      @(posedge clk); #1;
    end
    dout_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_abort();
    int guard = 0;
    int d0;
    d0 = done_cnt;
    dout_ready = 1'b1;
    pulse_start();
    load_words(16, 1'b0);
    while (!(core_state == 3'b011 && core_count == 7'd30) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (core_state !== 3'b000 || core_count !== 7'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got st=%0d cnt=%0d busy=%b required 0/0/0", core_state, core_count, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || core_state !== 3'b000) begin
      errors++;
      $display("FAIL abort_no_done got done=%0d st=%0d required done=0 st=0", done_cnt - d0, core_state);
    end
    test_abc();
  endtask

  task automatic test_reset_mid();
    int d0;
    logic [6:0] c0;
    dout_ready = 1'b1;
    pulse_start();
    load_words(7, 1'b0);
    win_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({core_state, core_count, win_ready, core_init, dout_valid, busy, done} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset got st=%0d cnt=%0d wr=%b ci=%b dv=%b busy=%b done=%b required all 0",
               core_state, core_count, win_ready, core_init, dout_valid, busy, done);
    end
    win_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || core_state !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_resume got busy=%b st=%0d required 0/0", busy, core_state);
    end
    d0 = done_cnt;
    pulse_start();
    push_abc();
    load_words(16, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    c0 = core_count;
    pulse_start();
    checks++;
    if (core_state !== 3'b011 || core_count !== c0 + 7'd1) begin
      errors++;
      $display("FAIL start_in_compress got st=%0d cnt=%0d required st=3 cnt=%0d", core_state, core_count, c0 + 7'd1);
    end
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL ignored_start_block got done=%0d busy=%b left=%0d required 1/0/0",
               done_cnt - d0, busy, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_toggle();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete, required completion before 500us");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_core_ctrl.md
SHA256_CORE_CTRL -- requirements
Module: sha256_core_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning message/digest word width.
REQ-002 SHALL have parameter N_ROUNDS, default 64, meaning compression round count.
REQ-003 SHALL have port clk input 1, meaning system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n input 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port start input 1, meaning request to hash one 512-bit block.
REQ-006 SHALL have port abort input 1, meaning synchronous cancel of the current block.
REQ-007 SHALL have port win_valid input 1, meaning a message word is presented.
REQ-008 SHALL have port win_ready output 1, meaning the controller accepts a message word this cycle.
REQ-009 SHALL have port core_state output 3, meaning the phase code driven to the expansion and compression datapath.
REQ-010 SHALL have port core_count output 7, meaning the word, round or digest index driven to the datapath.
REQ-011 SHALL have port core_init output 1, meaning a one-cycle pulse that reloads the datapath working registers with H0..H7.
REQ-012 SHALL have port dout_valid output 1, meaning a digest word is on the datapath output.
REQ-013 SHALL have port dout_ready input 1, meaning the consumer accepts a digest word.
REQ-014 SHALL have ports busy output 1 (not IDLE) and done output 1 (one-cycle pulse when the last digest word is accepted).

Function
REQ-015 SHALL implement states IDLE=3'b000, LOAD=3'b001, PRIME=3'b010, COMPRESS=3'b011, OUTPUT=3'b100, and drive the current state code on core_state.
REQ-016 SHALL, in IDLE, move to LOAD when start=1, pulse core_init for that same cycle, and clear core_count to 0.
REQ-017 SHALL, in LOAD, assert win_ready, increment core_count on each win_valid&&win_ready, and move to PRIME with core_count=0 when word 15 is accepted.
REQ-018 SHALL hold core_count in LOAD while win_valid=0, with no timeout.
REQ-019 SHALL spend exactly 1 cycle in PRIME, with core_count=0, then enter COMPRESS.
REQ-020 SHALL, in COMPRESS, increment core_count every cycle from 0 to N_ROUNDS-1 and enter OUTPUT with core_count=0 after round N_ROUNDS-1, giving exactly N_ROUNDS COMPRESS cycles.
REQ-021 SHALL, in OUTPUT, assert dout_valid, advance core_count 0..7 only on dout_ready, and on acceptance at count 7 pulse done and return to IDLE with core_count=0.
REQ-022 SHALL make latency from the last LOAD word accepted to the first dout_valid exactly N_ROUNDS+1 cycles.
REQ-023 SHALL ignore start when not in IDLE.
REQ-024 SHALL, when abort=1 in any state, go to IDLE next cycle with core_count=0, no done pulse, and abort taking priority over every other transition.
REQ-025 SHALL tie win_ready=0 outside LOAD and dout_valid=0 outside OUTPUT.
REQ-026 SHALL keep core_count within 7 bits and never wrap; reaching a terminal count always forces a state change.
REQ-027 SHALL, when start and done coincide, not start a new block in that cycle; start is sampled in IDLE only.

Reset
REQ-028 SHALL, on rst_n=0, immediately force state=IDLE, core_count=0, and win_ready, core_init, dout_valid, busy and done all 0.
REQ-029 SHALL discard a block interrupted by reset mid-operation; after reset release the block restarts only on a new start.

Structure
REQ-030 SHALL place the state codes, N_ROUNDS, word count 16 and digest count 8 in a shared package sha256_pkg used by the datapath blocks.
REQ-031 SHALL contain a single sub-module sha256_round_counter: a 7-bit counter with clear, enable and terminal-count compare.
REQ-032 SHALL use registered outputs for core_state and core_count, with no combinational path from dout_ready to win_ready.

Verification
REQ-033 SHALL cover: "abc" padded block (words 0x61626380, 0x0 x14, 0x00000018), dout_ready=1 -> digest words ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, done pulse once.
REQ-034 SHALL cover: win_valid toggled 1/0 every cycle in LOAD -> core_count advances only on valid cycles; PRIME entered after 16 accepts.
REQ-035 SHALL cover: dout_ready low 5 cycles at digest index 3 -> core_count holds at 3 with dout_valid=1 throughout.
REQ-036 SHALL cover: abort at COMPRESS round 30 -> IDLE next cycle, core_count=0, no done; a following "abc" block still yields ba7816bf first.
REQ-037 SHALL cover: rst_n low at LOAD word 7 -> all outputs 0 asynchronously; start pulse during COMPRESS ignored.
REQ-038 SHALL cover: cycle count from the 16th word accepted to the first dout_valid = 65.
